// File: rtl/product_accumulator.sv
// Signed product accumulator with valid/ready handshakes on both sides; emits the sum on the last term.
// Optional build macro PROD_ACC_SAT_EN clamps overflowing sums to the AW-bit signed limits instead of wrapping.
module product_accumulator #(
  parameter int PW    = 64,
  parameter int AW    = 72,
  parameter int CNT_W = 8
) (
  input  logic                 CLK,
  input  logic                 RESET,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic signed [PW-1:0] in_product,
  input  logic                 in_last,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic signed [AW-1:0] out_sum,
  output logic [CNT_W-1:0]     out_count,
  output logic                 out_overflow
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ACCUM,
    S_HOLD
  } state_t;

  state_t                r_state;
  state_t                w_state_next;
  logic signed [AW-1:0]  r_acc;
  logic [CNT_W-1:0]      r_cnt;
  logic                  r_ovf;
  logic signed [AW-1:0]  r_out_sum;
  logic [CNT_W-1:0]      r_out_count;
  logic                  r_out_ovf;

  logic                  w_accept;
  logic                  w_take;
  logic signed [AW-1:0]  w_prod_ext;
  logic signed [AW-1:0]  w_raw_sum;
  logic signed [AW-1:0]  w_sum;
  logic                  w_add_ovf;
  logic [CNT_W-1:0]      w_cnt_inc;

  // A result is pending exactly while the FSM sits in HOLD.
  assign out_valid    = (r_state == S_HOLD);
  assign out_sum      = r_out_sum;
  assign out_count    = r_out_count;
  assign out_overflow = r_out_ovf;

  assign in_ready = !RESET && !(out_valid && !out_ready);
  assign w_accept = in_valid && in_ready;
  assign w_take   = out_valid && out_ready;

  assign w_prod_ext = AW'(in_product);
  assign w_raw_sum  = r_acc + w_prod_ext;
  assign w_add_ovf  = (r_acc[AW-1] == w_prod_ext[AW-1]) && (w_raw_sum[AW-1] != r_acc[AW-1]);
  assign w_cnt_inc  = (&r_cnt) ? r_cnt : r_cnt + 1'b1;

`ifdef PROD_ACC_SAT_EN
  localparam logic signed [AW-1:0] SUM_MAX = {1'b0, {(AW-1){1'b1}}};
  localparam logic signed [AW-1:0] SUM_MIN = {1'b1, {(AW-1){1'b0}}};

  // Overflow direction follows the shared operand sign.
  assign w_sum = !w_add_ovf ? w_raw_sum : (r_acc[AW-1] ? SUM_MIN : SUM_MAX);
`else
  assign w_sum = w_raw_sum;
`endif

  // NOTE: every signal assigned in always_comb gets a default first, so no path can infer a latch.
  always_comb begin
    w_state_next = r_state;
    if (w_accept && in_last) begin
      w_state_next = S_HOLD;
    end else begin
      case (r_state)
        S_IDLE:  if (w_accept) w_state_next = S_ACCUM;
        S_ACCUM: w_state_next = S_ACCUM;
        S_HOLD:  if (w_take) w_state_next = w_accept ? S_ACCUM : S_IDLE;
        default: w_state_next = S_IDLE;
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_state     <= S_IDLE;
      r_acc       <= '0;
      r_cnt       <= '0;
      r_ovf       <= 1'b0;
      r_out_sum   <= '0;
      r_out_count <= '0;
      r_out_ovf   <= 1'b0;
    end else begin
      r_state <= w_state_next;
      if (w_accept) begin
        if (in_last) begin
          r_out_sum   <= w_sum;
          r_out_count <= w_cnt_inc;
          r_out_ovf   <= r_ovf | w_add_ovf;
          r_acc       <= '0;
          r_cnt       <= '0;
          r_ovf       <= 1'b0;
        end else begin
          r_acc <= w_sum;
          r_cnt <= w_cnt_inc;
          r_ovf <= r_ovf | w_add_ovf;
        end
      end
    end
  end

endmodule

// File: tb/tb_product_accumulator.sv
// Self-checking bench for product_accumulator: randomized and directed handshake traffic against a wide-integer reference model.
// A second instance with AW=PW=64 exercises the signed-overflow boundary.
module tb_product_accumulator;

  localparam int PW    = 64;
  localparam int AW    = 72;
  localparam int CNT_W = 8;
  localparam int AWB   = 64;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  typedef logic signed [127:0] big_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;

  logic                  a_in_valid, a_in_ready, a_in_last, a_out_valid, a_out_ready, a_out_overflow;
  logic signed [PW-1:0]  a_in_product;
  logic signed [AW-1:0]  a_out_sum;
  logic [CNT_W-1:0]      a_out_count;

  logic                  b_in_valid, b_in_ready, b_in_last, b_out_valid, b_out_ready, b_out_overflow;
  logic signed [PW-1:0]  b_in_product;
  logic signed [AWB-1:0] b_out_sum;
  logic [CNT_W-1:0]      b_out_count;

  product_accumulator #(.PW(PW), .AW(AW), .CNT_W(CNT_W)) u_dut (
    .CLK(clk), .RESET(rst),
    .in_valid(a_in_valid), .in_ready(a_in_ready), .in_product(a_in_product), .in_last(a_in_last),
    .out_valid(a_out_valid), .out_ready(a_out_ready), .out_sum(a_out_sum),
    .out_count(a_out_count), .out_overflow(a_out_overflow)
  );

  product_accumulator #(.PW(PW), .AW(AWB), .CNT_W(CNT_W)) u_dut64 (
    .CLK(clk), .RESET(rst),
    .in_valid(b_in_valid), .in_ready(b_in_ready), .in_product(b_in_product), .in_last(b_in_last),
    .out_valid(b_out_valid), .out_ready(b_out_ready), .out_sum(b_out_sum),
    .out_count(b_out_count), .out_overflow(b_out_overflow)
  );

  int n_vec = 0;
  int n_err = 0;

  // Reference model: exact integer sums, range-checked against the AW-bit signed limits.
  big_t m_acc, m_sum;
  int   m_cnt, m_count;
  bit   m_ovf, m_ovf_out, m_valid;

  function automatic void model_add(input big_t a, input big_t b, input int aw,
                                    output big_t s, output bit ovf);
    big_t t, mx, mn;
    t  = a + b;
    mx = (big_t'(1) <<< (aw - 1)) - 1;
    mn = -mx - 1;
    ovf = (t > mx) || (t < mn);
`ifdef PROD_ACC_SAT_EN
    if (t > mx) t = mx;
    else if (t < mn) t = mn;
`else
    t = (t <<< (128 - aw)) >>> (128 - aw);
`endif
    s = t;
  endfunction

  function automatic int sat_inc(input int c);
    return (c >= CNT_MAX) ? CNT_MAX : c + 1;
  endfunction

  task automatic model_reset();
    m_acc = 0; m_sum = 0; m_cnt = 0; m_count = 0;
    m_ovf = 0; m_ovf_out = 0; m_valid = 0;
  endtask

  task automatic drive(input bit iv, input logic [PW-1:0] prod, input bit last, input bit ordy);
    a_in_valid   = iv;
    a_in_product = prod;
    a_in_last    = last;
    a_out_ready  = ordy;
    #1;
  endtask

  // Advance one clock edge, updating the model from the handshake rules with the currently driven inputs.
  task automatic tick();
    bit   rdy, acc, take, o;
    big_t s;
    rdy  = !(m_valid && !a_out_ready);
    acc  = a_in_valid && rdy;
    take = m_valid && a_out_ready;
    if (acc) begin
      model_add(m_acc, big_t'(a_in_product), AW, s, o);
      if (a_in_last) begin
        m_sum = s; m_count = sat_inc(m_cnt); m_ovf_out = m_ovf | o; m_valid = 1;
        m_acc = 0; m_cnt = 0; m_ovf = 0;
      end else begin
        m_acc = s; m_cnt = sat_inc(m_cnt); m_ovf = m_ovf | o;
        if (take) m_valid = 0;
      end
    end else if (take) begin
      m_valid = 0;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    drive(0, '0, 0, 0);
    b_in_valid = 0; b_in_product = '0; b_in_last = 0; b_out_ready = 0;
    rst = 1;
    #1;
    n_vec++;
    if (a_in_ready !== 1'b0) begin
      n_err++; $display("FAIL reset_in_ready_low: got %0b want 0", a_in_ready);
    end
    @(posedge clk);
    #1;
    model_reset();
    n_vec++;
    if ({a_out_valid, a_out_sum, a_out_count, a_out_overflow} !== '0) begin
      n_err++;
      $display("FAIL reset_outputs: got v=%0b sum=%0d cnt=%0d ovf=%0b want all 0",
               a_out_valid, a_out_sum, a_out_count, a_out_overflow);
    end
    rst = 0;
    #1;
    n_vec++;
    if (a_in_ready !== 1'b1) begin
      n_err++; $display("FAIL reset_in_ready_high: got %0b want 1", a_in_ready);
    end
  endtask

  task automatic test_reset();
    do_reset();
  endtask

  task automatic test_basic();
    drive(1, -64'sd465, 0, 1); tick();
    drive(1, 64'sd377, 1, 1);  tick();
    n_vec++;
    if ({a_out_valid, a_out_sum, a_out_count, a_out_overflow} !==
        {1'b1, AW'(-72'sd88), CNT_W'(2), 1'b0}) begin
      n_err++;
      $display("FAIL basic_two_terms: got v=%0b sum=%0d cnt=%0d ovf=%0b want v=1 sum=-88 cnt=2 ovf=0",
               a_out_valid, a_out_sum, a_out_count, a_out_overflow);
    end
    drive(1, 64'sd122, 1, 1); tick();
    n_vec++;
    if ({a_out_valid, a_out_sum, a_out_count, a_out_overflow} !==
        {m_valid, m_sum[AW-1:0], m_count[CNT_W-1:0], m_ovf_out} || m_sum != 122 || m_count != 1) begin
      n_err++;
      $display("FAIL basic_single_term: got v=%0b sum=%0d cnt=%0d want v=1 sum=122 cnt=1",
               a_out_valid, a_out_sum, a_out_count);
    end
    drive(0, '0, 0, 1); tick();
    n_vec++;
    if (a_out_valid !== 1'b0) begin
      n_err++; $display("FAIL basic_valid_drops: got %0b want 0", a_out_valid);
    end
  endtask

  task automatic test_backpressure();
    drive(1, 64'sd1000, 1, 0); tick();
    for (int i = 0; i < 5; i++) begin
      drive(1, 64'($urandom), $urandom_range(0, 1), 0);
      n_vec++;
      if (a_in_ready !== 1'b0) begin
        n_err++; $display("FAIL hold_in_ready: cycle %0d got %0b want 0", i, a_in_ready);
      end
      tick();
      n_vec++;
      if ({a_out_valid, a_out_sum, a_out_count, a_out_overflow} !== {1'b1, AW'(1000), CNT_W'(1), 1'b0}) begin
        n_err++;
        $display("FAIL hold_outputs: cycle %0d got v=%0b sum=%0d cnt=%0d want v=1 sum=1000 cnt=1",
                 i, a_out_valid, a_out_sum, a_out_count);
      end
    end
    drive(1, 64'sd670325140, 1, 1);
    n_vec++;
    if (a_in_ready !== 1'b1) begin
      n_err++; $display("FAIL take_in_ready: got %0b want 1", a_in_ready);
    end
    tick();
    n_vec++;
    if ({a_out_valid, a_out_sum, a_out_count} !== {1'b1, AW'(670325140), CNT_W'(1)}) begin
      n_err++;
      $display("FAIL take_and_reload: got v=%0b sum=%0d cnt=%0d want v=1 sum=670325140 cnt=1",
               a_out_valid, a_out_sum, a_out_count);
    end
    drive(0, '0, 0, 1); tick();
  endtask

  task automatic test_overflow();
    logic signed [AWB-1:0] exp_sum;
`ifdef PROD_ACC_SAT_EN
    exp_sum = 64'sh7FFF_FFFF_FFFF_FFFF;
`else
    exp_sum = 64'sh8000_0000_0000_0000;
`endif
    b_out_ready = 1; b_in_valid = 1; b_in_product = 64'sh7FFF_FFFF_FFFF_FFFF; b_in_last = 0;
    drive(0, '0, 0, 1); tick();
    b_in_product = 64'sd1; b_in_last = 1;
    tick();
    b_in_valid = 0; b_in_last = 0;
    n_vec++;
    if ({b_out_valid, b_out_overflow, b_out_sum, b_out_count} !== {1'b1, 1'b1, exp_sum, CNT_W'(2)}) begin
      n_err++;
      $display("FAIL overflow_64: got v=%0b ovf=%0b sum=%0d cnt=%0d want v=1 ovf=1 sum=%0d cnt=2",
               b_out_valid, b_out_overflow, b_out_sum, b_out_count, exp_sum);
    end
    tick();
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < 3; i++) begin
      drive(1, 64'($urandom_range(1, 5000)), 0, 1); tick();
    end
    do_reset();
    drive(1, 64'sd0, 0, 1);    tick();
    drive(1, -64'sd300, 1, 1); tick();
    n_vec++;
    if ({a_out_valid, a_out_sum, a_out_count, a_out_overflow} !==
        {1'b1, AW'(-72'sd300), CNT_W'(2), 1'b0}) begin
      n_err++;
      $display("FAIL reset_mid_sum: got v=%0b sum=%0d cnt=%0d ovf=%0b want v=1 sum=-300 cnt=2 ovf=0",
               a_out_valid, a_out_sum, a_out_count, a_out_overflow);
    end
    drive(0, '0, 0, 1); tick();
  endtask

  task automatic test_count_saturation();
    for (int i = 1; i <= 300; i++) begin
      drive(1, 64'sd1, (i == 300), 1); tick();
    end
    n_vec++;
    if ({a_out_valid, a_out_sum, a_out_count} !== {1'b1, AW'(300), CNT_W'(CNT_MAX)}) begin
      n_err++;
      $display("FAIL count_saturates: got v=%0b sum=%0d cnt=%0d want v=1 sum=300 cnt=%0d",
               a_out_valid, a_out_sum, a_out_count, CNT_MAX);
    end
    drive(0, '0, 0, 1); tick();
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 20; i++) begin
      drive(1, {$urandom, $urandom}, 1, 1);
      tick();
      n_vec++;
      if ({a_out_valid, a_out_sum, a_out_count, a_out_overflow} !==
          {m_valid, m_sum[AW-1:0], m_count[CNT_W-1:0], m_ovf_out}) begin
        n_err++;
        $display("FAIL back_to_back: cycle %0d got v=%0b sum=%0d cnt=%0d want v=%0b sum=%0d cnt=%0d",
                 i, a_out_valid, a_out_sum, a_out_count, m_valid, m_sum, m_count);
      end
    end
    drive(0, '0, 0, 1); tick();
  endtask

  task automatic test_random();
    bit exp_rdy;
    for (int i = 0; i < 600; i++) begin
      drive($urandom_range(0, 3) != 0,
            ($urandom_range(0, 3) == 0) ? {$urandom, $urandom} : 64'($signed(16'($urandom))),
            $urandom_range(0, 4) == 0, $urandom_range(0, 2) != 0);
      exp_rdy = !(m_valid && !a_out_ready);
      n_vec++;
      if (a_in_ready !== exp_rdy) begin
        n_err++; $display("FAIL random_in_ready: cycle %0d got %0b want %0b", i, a_in_ready, exp_rdy);
      end
      tick();
      n_vec++;
      if ({a_out_valid, a_out_sum, a_out_count, a_out_overflow} !==
          {m_valid, m_sum[AW-1:0], m_count[CNT_W-1:0], m_ovf_out}) begin
        n_err++;
        $display("FAIL random_outputs: cycle %0d got v=%0b sum=%0d cnt=%0d ovf=%0b want v=%0b sum=%0d cnt=%0d ovf=%0b",
                 i, a_out_valid, a_out_sum, a_out_count, a_out_overflow, m_valid, m_sum, m_count, m_ovf_out);
      end
    end
  endtask

  initial begin
    rst = 1;
    a_in_valid = 0; a_in_product = '0; a_in_last = 0; a_out_ready = 0;
    b_in_valid = 0; b_in_product = '0; b_in_last = 0; b_out_ready = 0;
    model_reset();
    @(posedge clk);
    #1;
    test_reset();
    test_basic();
    test_backpressure();
    test_overflow();
    test_reset_mid();
    test_count_saturation();
    test_back_to_back();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
